// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory arbiter: FSM states, grant
// encodings and the word-alignment helper used on the Avalon address.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2,
      GNT_WB   = 2'd3
   } grant_t;

   localparam logic [3:0] BE_ALL = 4'b1111;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational grant selection: a full or starved write buffer wins, then
// the D-cache, then the I-cache, then an ordinary write-buffer drain.
module mips_arb_pick
   import mips_mem_pkg::*;
(
   input  logic   i_i_req,
   input  logic   i_d_req,
   input  logic   i_wb_valid,
   input  logic   i_wb_full,
   input  logic   i_starve,
   output grant_t o_grant
);

   always_comb begin
      o_grant = GNT_NONE;
      if (i_wb_full || (i_wb_valid && i_starve)) begin
         o_grant = GNT_WB;
      end else if (i_d_req) begin
         o_grant = GNT_D;
      end else if (i_i_req) begin
         o_grant = GNT_I;
      end else if (i_wb_valid) begin
         o_grant = GNT_WB;
      end
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-MM master between I-cache refill, D-cache refill and the
// write-buffer drain, one transaction at a time, with bounded write starvation.
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read,
   input  logic [31:0] i_addr,
   output logic [31:0] i_readdata,
   output logic        i_ready,
   input  logic        d_read,
   input  logic [31:0] d_addr,
   output logic [31:0] d_readdata,
   output logic        d_ready,
   input  logic        wb_valid,
   input  logic        wb_full,
   input  logic [31:0] wb_addr,
   input  logic [31:0] wb_data,
   input  logic [3:0]  wb_byteenable,
   output logic        wb_pop,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

   arb_state_t    r_state, w_state_next;
   grant_t        r_grant, w_grant_next;
   logic [SW-1:0] r_streak, w_streak_next;
   logic [31:0]   r_avm_address, w_avm_address_next;
   logic          r_avm_read, w_avm_read_next;
   logic          r_avm_write, w_avm_write_next;
   logic [31:0]   r_avm_writedata, w_avm_writedata_next;
   logic [3:0]    r_avm_byteenable, w_avm_byteenable_next;
   logic [31:0]   r_i_readdata, w_i_readdata_next;
   logic [31:0]   r_d_readdata, w_d_readdata_next;
   logic          r_i_ready, w_i_ready_next;
   logic          r_d_ready, w_d_ready_next;
   logic          r_wb_pop, w_wb_pop_next;

   grant_t        w_pick;
   logic          w_starve;

   assign w_starve = (r_streak == STREAK_MAX);

   mips_arb_pick u_pick (
      .i_i_req    (i_read),
      .i_d_req    (d_read),
      .i_wb_valid (wb_valid),
      .i_wb_full  (wb_full),
      .i_starve   (w_starve),
      .o_grant    (w_pick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= IDLE;
         r_grant          <= GNT_NONE;
         r_streak         <= '0;
         r_avm_address    <= '0;
         r_avm_read       <= 1'b0;
         r_avm_write      <= 1'b0;
         r_avm_writedata  <= '0;
         r_avm_byteenable <= '0;
         r_i_readdata     <= '0;
         r_d_readdata     <= '0;
         r_i_ready        <= 1'b0;
         r_d_ready        <= 1'b0;
         r_wb_pop         <= 1'b0;
      end else begin
         r_state          <= w_state_next;
         r_grant          <= w_grant_next;
         r_streak         <= w_streak_next;
         r_avm_address    <= w_avm_address_next;
         r_avm_read       <= w_avm_read_next;
         r_avm_write      <= w_avm_write_next;
         r_avm_writedata  <= w_avm_writedata_next;
         r_avm_byteenable <= w_avm_byteenable_next;
         r_i_readdata     <= w_i_readdata_next;
         r_d_readdata     <= w_d_readdata_next;
         r_i_ready        <= w_i_ready_next;
         r_d_ready        <= w_d_ready_next;
         r_wb_pop         <= w_wb_pop_next;
      end
   end

   always_comb begin
      w_state_next          = r_state;
      w_grant_next          = r_grant;
      w_streak_next         = r_streak;
      w_avm_address_next    = r_avm_address;
      w_avm_read_next       = r_avm_read;
      w_avm_write_next      = r_avm_write;
      w_avm_writedata_next  = r_avm_writedata;
      w_avm_byteenable_next = r_avm_byteenable;
      w_i_readdata_next     = r_i_readdata;
      w_d_readdata_next     = r_d_readdata;
      w_i_ready_next        = 1'b0;
      w_d_ready_next        = 1'b0;
      w_wb_pop_next         = 1'b0;

      case (r_state)
         IDLE: begin
            if (!wb_valid) begin
               w_streak_next = '0;
            end
            w_grant_next = w_pick;
            case (w_pick)
               GNT_WB: begin
                  w_state_next          = BUS;
                  w_streak_next         = '0;
                  w_avm_address_next    = word_addr(wb_addr);
                  w_avm_write_next      = 1'b1;
                  w_avm_writedata_next  = wb_data;
                  w_avm_byteenable_next = wb_byteenable;
               end
               GNT_D, GNT_I: begin
                  w_state_next          = BUS;
                  w_avm_address_next    = word_addr((w_pick == GNT_D) ? d_addr : i_addr);
                  w_avm_read_next       = 1'b1;
                  w_avm_writedata_next  = '0;
                  w_avm_byteenable_next = BE_ALL;
                  // Only reads that bypass a waiting write count toward starvation.
                  if (wb_valid && !w_starve) begin
                     w_streak_next = r_streak + SW'(1);
                  end
               end
               default: ;
            endcase
         end
         BUS: begin
            if (!avm_waitrequest) begin
               w_state_next     = DONE;
               w_avm_read_next  = 1'b0;
               w_avm_write_next = 1'b0;
               case (r_grant)
                  GNT_I: begin
                     w_i_readdata_next = avm_readdata;
                     w_i_ready_next    = 1'b1;
                  end
                  GNT_D: begin
                     w_d_readdata_next = avm_readdata;
                     w_d_ready_next    = 1'b1;
                  end
                  GNT_WB:  w_wb_pop_next = 1'b1;
                  default: ;
               endcase
            end
         end
         DONE: begin
            w_state_next = IDLE;
            w_grant_next = GNT_NONE;
         end
         default: begin
            w_state_next = IDLE;
            w_grant_next = GNT_NONE;
         end
      endcase
   end

   assign i_readdata     = r_i_readdata;
   assign i_ready        = r_i_ready;
   assign d_readdata     = r_d_readdata;
   assign d_ready        = r_d_ready;
   assign wb_pop         = r_wb_pop;
   assign avm_address    = r_avm_address;
   assign avm_read       = r_avm_read;
   assign avm_write      = r_avm_write;
   assign avm_writedata  = r_avm_writedata;
   assign avm_byteenable = r_avm_byteenable;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed vector table, corner-case
// sequences and randomized traffic checked by a transaction-level model.
module tb_mips_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read, d_read, wb_valid, wb_full, avm_waitrequest;
   logic [31:0] i_addr, d_addr, wb_addr, wb_data, avm_readdata;
   logic [3:0]  wb_byteenable;
   logic [31:0] i_readdata, d_readdata, avm_address, avm_writedata;
   logic        i_ready, d_ready, wb_pop, avm_read, avm_write;
   logic [3:0]  avm_byteenable;

   mips_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_readdata(i_readdata), .i_ready(i_ready),
      .d_read(d_read), .d_addr(d_addr), .d_readdata(d_readdata), .d_ready(d_ready),
      .wb_valid(wb_valid), .wb_full(wb_full), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_byteenable(wb_byteenable), .wb_pop(wb_pop),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } wb_ent_t;

   typedef struct {
      logic ir, dr, wv, wf;
      int   waits;
      int   exp_port;
      int   exp_lat;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   wb_ent_t wbq[$];
   int      wb_depth  = 4;
   bit      i_hold    = 0;
   bit      d_hold    = 0;
   bit      rand_mode = 0;
   int      cur_waits = 0;
   int      bus_cnt   = 0;

   // Reference model: 0 = next edge decides a grant, 1 = on the bus, 2 = completion cycle.
   int          m_phase  = 0;
   int          m_grant  = 0;
   int          m_streak = 0;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_i_rd = '0, m_d_rd = '0;
   bit          done_evt;
   int          done_port;
   int          n_done = 0;
   int          done_log[$];
   int          done_cyc[$];

   logic        s_rst, s_ir, s_dr, s_wv, s_wf, s_wr;
   logic [31:0] s_rdata, s_iaddr, s_daddr, s_wba, s_wbd;
   logic [3:0]  s_wbbe;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic int exp_grant(input logic ir, input logic dr, input logic wv,
                                    input logic wf, input int streak);
      if (wf || (wv && streak == 4)) return 3;
      if (dr) return 2;
      if (ir) return 1;
      if (wv) return 3;
      return 0;
   endfunction

   function automatic int logp(input int i);
      if (i < done_log.size()) return done_log[i];
      return -1;
   endfunction

   function automatic int gapp(input int i);
      if (i + 1 < done_cyc.size()) return done_cyc[i+1] - done_cyc[i];
      return -1;
   endfunction

   task automatic update_wb();
      wb_valid = (wbq.size() != 0);
      wb_full  = (wbq.size() >= wb_depth);
      if (wbq.size() != 0) begin
         wb_addr = wbq[0].a; wb_data = wbq[0].d; wb_byteenable = wbq[0].be;
      end else begin
         wb_addr = '0; wb_data = '0; wb_byteenable = '0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_i_rdata"}, i_readdata, 32'h0);
      check({tag, "_d_rdata"}, d_readdata, 32'h0);
      check({tag, "_i_ready"}, {31'h0, i_ready}, 32'h0);
      check({tag, "_d_ready"}, {31'h0, d_ready}, 32'h0);
      check({tag, "_wb_pop"},  {31'h0, wb_pop}, 32'h0);
      check({tag, "_addr"},    avm_address, 32'h0);
      check({tag, "_rd"},      {31'h0, avm_read}, 32'h0);
      check({tag, "_wr"},      {31'h0, avm_write}, 32'h0);
      check({tag, "_wdata"},   avm_writedata, 32'h0);
      check({tag, "_be"},      {28'h0, avm_byteenable}, 32'h0);
   endtask

   task automatic check_pulses(input int port);
      check("i_ready", {31'h0, i_ready}, (port == 1) ? 32'h1 : 32'h0);
      check("d_ready", {31'h0, d_ready}, (port == 2) ? 32'h1 : 32'h0);
      check("wb_pop",  {31'h0, wb_pop},  (port == 3) ? 32'h1 : 32'h0);
   endtask

   task automatic model_step();
      int g;
      case (m_phase)
         0: begin
            g = exp_grant(s_ir, s_dr, s_wv, s_wf, m_streak);
            if (g == 3 || !s_wv) m_streak = 0;
            else if (g != 0)     m_streak = (m_streak < 4) ? m_streak + 1 : 4;
            if (g == 0) begin
               check("idle_rd", {31'h0, avm_read}, 32'h0);
               check("idle_wr", {31'h0, avm_write}, 32'h0);
            end else begin
               m_grant = g;
               m_addr  = (g == 1) ? s_iaddr : (g == 2) ? s_daddr : s_wba;
               m_addr[1:0] = 2'b00;
               m_be    = (g == 3) ? s_wbbe : 4'hF;
               m_wdata = s_wbd;
               check("start_rd",   {31'h0, avm_read},  (g != 3) ? 32'h1 : 32'h0);
               check("start_wr",   {31'h0, avm_write}, (g == 3) ? 32'h1 : 32'h0);
               check("start_addr", avm_address, m_addr);
               check("start_be",   {28'h0, avm_byteenable}, {28'h0, m_be});
               if (g == 3) check("start_wdata", avm_writedata, m_wdata);
               m_phase = 1;
               bus_cnt = 0;
               if (rand_mode) cur_waits = $urandom_range(0, 3);
            end
            check_pulses(0);
         end
         1: begin
            if (s_wr) begin
               bus_cnt++;
               check("hold_rd",   {31'h0, avm_read},  (m_grant != 3) ? 32'h1 : 32'h0);
               check("hold_wr",   {31'h0, avm_write}, (m_grant == 3) ? 32'h1 : 32'h0);
               check("hold_addr", avm_address, m_addr);
               check("hold_be",   {28'h0, avm_byteenable}, {28'h0, m_be});
               if (m_grant == 3) check("hold_wdata", avm_writedata, m_wdata);
               check_pulses(0);
            end else begin
               check("done_rd", {31'h0, avm_read}, 32'h0);
               check("done_wr", {31'h0, avm_write}, 32'h0);
               check_pulses(m_grant);
               if (m_grant == 1) m_i_rd = s_rdata;
               if (m_grant == 2) m_d_rd = s_rdata;
               m_phase   = 2;
               done_evt  = 1;
               done_port = m_grant;
               n_done++;
               done_log.push_back(m_grant);
               done_cyc.push_back(cyc);
               $display("[TB] txn %0d port=%s addr=%h cycle=%0d", n_done,
                        (m_grant == 1) ? "I" : (m_grant == 2) ? "D" : "WB", m_addr, cyc);
            end
         end
         default: begin
            check("idle_rd", {31'h0, avm_read}, 32'h0);
            check("idle_wr", {31'h0, avm_write}, 32'h0);
            check_pulses(0);
            m_phase = 0;
         end
      endcase
      check("i_readdata", i_readdata, m_i_rd);
      check("d_readdata", d_readdata, m_d_rd);
   endtask

   task automatic random_stim();
      if (!i_read && $urandom_range(0, 3) == 0) begin i_read = 1'b1; i_addr = $urandom; end
      if (!d_read && $urandom_range(0, 3) == 0) begin d_read = 1'b1; d_addr = $urandom; end
      if (wbq.size() < wb_depth && $urandom_range(0, 3) == 0)
         wbq.push_back('{a: $urandom, d: $urandom, be: 4'($urandom)});
   endtask

   task automatic tick();
      s_rst = rst; s_ir = i_read; s_dr = d_read; s_wv = wb_valid; s_wf = wb_full;
      s_wr = avm_waitrequest; s_rdata = avm_readdata; s_iaddr = i_addr; s_daddr = d_addr;
      s_wba = wb_addr; s_wbd = wb_data; s_wbbe = wb_byteenable;
      @(posedge clk);
      #1;
      cyc++;
      done_evt = 0;
      if (!s_rst || !rst) begin
         check_reset_outputs("rst_hold");
         m_phase = 0; m_streak = 0; m_i_rd = '0; m_d_rd = '0; bus_cnt = 0;
      end else begin
         model_step();
      end
      if (i_ready && !i_hold) i_read = 1'b0;
      if (d_ready && !d_hold) d_read = 1'b0;
      if (wb_pop && wbq.size() != 0) void'(wbq.pop_front());
      if (rand_mode) random_stim();
      update_wb();
      avm_readdata = $urandom;
      if (m_phase == 1) avm_waitrequest = (bus_cnt < cur_waits);
      else              avm_waitrequest = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      i_read = 1'b0; d_read = 1'b0; i_hold = 0; d_hold = 0;
      wbq.delete(); wb_depth = 4; update_wb();
      rst = 1'b0;
      #1;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic run_seq(input int n, input int budget);
      int c;
      c = 0;
      done_log.delete();
      done_cyc.delete();
      while (done_log.size() < n && c < budget) begin
         tick();
         c++;
      end
      check("seq_count", done_log.size(), n);
   endtask

   vec_t tbl[9];

   initial begin
      int t0, lat, port;
      bit seen;
      int n_before;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 3};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 1, 8};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 3};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 4};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 3};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 3, 3};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 2, 5};
      tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 4};

      rst = 1'b0;
      i_read = 1'b0; d_read = 1'b0; i_addr = '0; d_addr = '0;
      avm_readdata = '0; avm_waitrequest = 1'b0;
      update_wb();

      for (int k = 0; k < 9; k++) begin
         do_reset();
         wb_depth = tbl[k].wf ? 1 : 4;
         if (tbl[k].wv)
            wbq.push_back('{a: 32'h0000_3002 + 32'(k), d: 32'hC0DE_0000 + 32'(k), be: 4'b0011});
         i_read = tbl[k].ir; i_addr = 32'h0000_2006 + 32'(k * 16);
         d_read = tbl[k].dr; d_addr = 32'h0000_1003;
         cur_waits = tbl[k].waits;
         update_wb();
         t0 = cyc; seen = 0; lat = 0; port = 0;
         for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (done_evt) begin seen = 1; lat = cyc - t0 + 1; port = done_port; end
         end
         if (tbl[k].exp_port == 0) begin
            check("tbl_none", {31'h0, seen}, 32'h0);
         end else begin
            check("tbl_port", port, tbl[k].exp_port);
            check("tbl_lat", lat, tbl[k].exp_lat);
         end
      end

      // Reset in the middle of a stalled write: the entry must be replayed.
      do_reset();
      wbq.push_back('{a: 32'h0000_3002, d: 32'hDEAD_BEEF, be: 4'b0101});
      cur_waits = 10;
      update_wb();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      check("rst_entry_kept", wbq.size(), 1);
      tick();
      tick();
      rst = 1'b1;
      cur_waits = 0;
      run_seq(1, 10);
      check("replay_port", logp(0), 3);
      check("replay_drained", wbq.size(), 0);

      // Contention: D, then I, then WB with one idle bus cycle between.
      do_reset();
      cur_waits = 0;
      i_read = 1'b1; i_addr = 32'h0000_4004;
      d_read = 1'b1; d_addr = 32'h0000_5008;
      wbq.push_back('{a: 32'h0000_600C, d: 32'h1234_5678, be: 4'b1111});
      update_wb();
      run_seq(3, 30);
      check("cont_0", logp(0), 2);
      check("cont_1", logp(1), 1);
      check("cont_2", logp(2), 3);
      check("cont_gap0", gapp(0), 3);
      check("cont_gap1", gapp(1), 3);

      // Starvation: continuous D reads with pending writes.
      do_reset();
      cur_waits = 0;
      d_hold = 1; d_read = 1'b1; d_addr = 32'h0000_7000;
      wbq.push_back('{a: 32'h0000_8000, d: 32'hAAAA_0001, be: 4'b1000});
      wbq.push_back('{a: 32'h0000_8004, d: 32'hAAAA_0002, be: 4'b0001});
      update_wb();
      run_seq(7, 60);
      for (int j = 0; j < 7; j++) check("starve_seq", logp(j), (j == 4) ? 3 : 2);
      d_hold = 0;

      // Full write buffer overrides a pending D read.
      do_reset();
      cur_waits = 1;
      wb_depth = 1;
      wbq.push_back('{a: 32'h0000_9000, d: 32'h5555_AAAA, be: 4'b0110});
      d_read = 1'b1; d_addr = 32'h0000_A00C;
      update_wb();
      run_seq(2, 30);
      check("full_0", logp(0), 3);
      check("full_1", logp(1), 2);

      // Randomized traffic against the reference model.
      do_reset();
      n_before = n_done;
      rand_mode = 1;
      for (int c = 0; c < 2500; c++) tick();
      rand_mode = 0;
      check("rand_progress", {31'h0, (n_done - n_before) > 100}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
